// File: rtl/vga_fb_writer_pkg.sv
// Shared constants, opcode/state/mode enums and the per-command write-count helper
// for the character frame-buffer write engine.
package vga_fb_writer_pkg;

   localparam int COLS  = 40;
   localparam int ROWS  = 30;
   localparam int XW    = 6;
   localparam int YW    = 5;
   localparam int CW    = 3;
   localparam int AW    = XW + YW;
   localparam int LW    = 6;
   localparam int NW    = 11;
   localparam int CELLS = COLS * ROWS;

   typedef enum logic [1:0] {
      OP_PLOT  = 2'd0,
      OP_HLINE = 2'd1,
      OP_VLINE = 2'd2,
      OP_FILL  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      MODE_H      = 2'd0,
      MODE_V      = 2'd1,
      MODE_RASTER = 2'd2
   } mode_e;

   // Number of cells a command will write after clipping; zero means the
   // engine skips RUN and goes straight to DONE.
   function automatic logic [NW-1:0] write_count(
      input op_e            op,
      input logic [XW-1:0]  x,
      input logic [YW-1:0]  y,
      input logic [LW-1:0]  len
   );
      logic [NW-1:0] span;
      logic [NW-1:0] len_w;
      logic          on_screen;
      span      = '0;
      len_w     = NW'(len);
      on_screen = (x < XW'(COLS)) && (y < YW'(ROWS));
      write_count = '0;
      case (op)
         OP_PLOT: begin
            write_count = on_screen ? NW'(1) : '0;
         end
         OP_HLINE: begin
            span = NW'(COLS) - NW'(x);
            if (on_screen)
               write_count = (len_w < span) ? len_w : span;
         end
         OP_VLINE: begin
            span = NW'(ROWS) - NW'(y);
            if (on_screen)
               write_count = (len_w < span) ? len_w : span;
         end
         OP_FILL: begin
            write_count = NW'(CELLS);
         end
         default: begin
            write_count = '0;
         end
      endcase
   endfunction

endpackage

// File: rtl/vga_fb_writer_cursor.sv
// Cell cursor for the frame-buffer writer: holds cx/cy and the remaining write
// count, and advances horizontally, vertically or in raster order.
module fb_cursor
   import vga_fb_writer_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  mode_e         mode,
   input  logic [XW-1:0] x_start,
   input  logic [YW-1:0] y_start,
   input  logic [NW-1:0] count,
   output logic [XW-1:0] cx,
   output logic [YW-1:0] cy,
   output logic          last
);

   logic [NW-1:0] remaining;
   mode_e         mode_q;

   // Load wins over step; the mode is captured at load so the top only has
   // to present it alongside the accepted command.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cx        <= '0;
         cy        <= '0;
         remaining <= '0;
         mode_q    <= MODE_H;
      end else if (load) begin
         cx        <= x_start;
         cy        <= y_start;
         remaining <= count;
         mode_q    <= mode;
      end else if (step) begin
         remaining <= remaining - NW'(1);
         case (mode_q)
            MODE_H: begin
               cx <= cx + XW'(1);
            end
            MODE_V: begin
               cy <= cy + YW'(1);
            end
            MODE_RASTER: begin
               if (cx == XW'(COLS - 1)) begin
                  cx <= '0;
                  cy <= cy + YW'(1);
               end else begin
                  cx <= cx + XW'(1);
               end
            end
            default: begin
               cx <= cx;
            end
         endcase
      end
   end

   assign last = (remaining == NW'(1));

endmodule

// File: rtl/vga_fb_writer.sv
// Write-side engine for the 40x30 character frame buffer: accepts drawing
// commands over valid/ready and emits one RAM port-A write per clock.
module vga_fb_writer
   import vga_fb_writer_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [XW-1:0] cmd_x,
   input  logic [YW-1:0] cmd_y,
   input  logic [LW-1:0] cmd_len,
   input  logic [CW-1:0] cmd_color,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] addra,
   output logic [CW-1:0] dina,
   output logic          wea
);

   state_e        state;
   state_e        state_next;
   op_e           op_in;
   mode_e         mode_in;
   logic          accept;
   logic          running;
   logic [NW-1:0] count_start;
   logic [XW-1:0] x_start;
   logic [YW-1:0] y_start;
   logic [XW-1:0] cx;
   logic [YW-1:0] cy;
   logic          last;
   logic [CW-1:0] color_q;
   logic [AW-1:0] addr_hold;
   logic [CW-1:0] dina_hold;

   assign op_in       = op_e'(cmd_op);
   assign accept      = cmd_valid && (state == ST_IDLE);
   assign running     = (state == ST_RUN);
   assign count_start = write_count(op_in, cmd_x, cmd_y, cmd_len);

   // FILL ignores the command coordinates and always sweeps from the origin.
   always_comb begin
      mode_in = MODE_H;
      x_start = cmd_x;
      y_start = cmd_y;
      case (op_in)
         OP_VLINE: mode_in = MODE_V;
         OP_FILL: begin
            mode_in = MODE_RASTER;
            x_start = '0;
            y_start = '0;
         end
         default: mode_in = MODE_H;
      endcase
   end

   fb_cursor u_cursor (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .step    (running),
      .mode    (mode_in),
      .x_start (x_start),
      .y_start (y_start),
      .count   (count_start),
      .cx      (cx),
      .cy      (cy),
      .last    (last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Fully clipped commands skip RUN so they still produce a done pulse.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept)
               state_next = (count_start == '0) ? ST_DONE : ST_RUN;
         end
         ST_RUN: begin
            if (last)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The hold registers keep addra/dina stable at the last written cell
   // whenever the engine is not actively writing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         color_q   <= '0;
         addr_hold <= '0;
         dina_hold <= '0;
      end else begin
         if (accept)
            color_q <= cmd_color;
         if (running) begin
            addr_hold <= {cy, cx};
            dina_hold <= color_q;
         end
      end
   end

   assign wea       = running;
   assign addra     = running ? {cy, cx} : addr_hold;
   assign dina      = running ? color_q : dina_hold;
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = !cmd_ready;
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_vga_fb_writer.sv
// Directed bench for vga_fb_writer: a vector table of commands with hand-computed
// write counts and addresses, plus sequences for busy-hold and mid-FILL reset.
module tb_vga_fb_writer;
   import vga_fb_writer_pkg::*;

   typedef struct {
      logic [1:0] op;
      logic [5:0] x;
      logic [4:0] y;
      logic [5:0] len;
      logic [2:0] color;
      int         exp_writes;
      int         exp_first;
      int         exp_last;
   } vec_t;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [5:0]  cmd_x;
   logic [4:0]  cmd_y;
   logic [5:0]  cmd_len;
   logic [2:0]  cmd_color;
   logic        busy;
   logic        done;
   logic [10:0] addra;
   logic [2:0]  dina;
   logic        wea;

   int checks;
   int errors;
   int prev_addr;
   int bad_addr;
   logic [2:0] ram [0:2047];
   vec_t vectors [10];

   vga_fb_writer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_x     (cmd_x),
      .cmd_y     (cmd_y),
      .cmd_len   (cmd_len),
      .cmd_color (cmd_color),
      .busy      (busy),
      .done      (done),
      .addra     (addra),
      .dina      (dina),
      .wea       (wea)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model sampled mid-cycle; also flags any write to an off-screen cell.
   always @(negedge clk) begin
      if (wea && !rst) begin
         ram[addra] = dina;
         if ((addra[5:0] >= 6'd40) || (addra[10:6] >= 5'd30))
            bad_addr++;
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitReady();
      int guard;
      guard = 0;
      while (!cmd_ready && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 2000)
         checkOutput("ready_timeout", 0, 1);
   endtask

   task automatic applyStimulus(input vec_t v);
      int writes;
      int first;
      int last_a;
      int bad_data;
      int gaps;
      int got_done;
      int done_wea;
      int done_addr;
      waitReady();
      cmd_op    = v.op;
      cmd_x     = v.x;
      cmd_y     = v.y;
      cmd_len   = v.len;
      cmd_color = v.color;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("busy_after_accept", int'(busy), 1);
      writes = 0; first = -1; last_a = -1; bad_data = 0; gaps = 0;
      got_done = 0; done_wea = 0; done_addr = -1;
      for (int c = 0; c < 1300 && got_done == 0; c++) begin
         if (wea) begin
            if (writes == 0) first = int'(addra);
            last_a = int'(addra);
            if (dina != v.color) bad_data++;
            writes++;
         end
         if (done) begin
            got_done  = 1;
            done_wea  = int'(wea);
            done_addr = int'(addra);
         end else begin
            if (!wea) gaps++;
            @(negedge clk);
         end
      end
      checkOutput("done_seen", got_done, 1);
      checkOutput("write_count", writes, v.exp_writes);
      checkOutput("wea_in_done", done_wea, 0);
      checkOutput("write_gaps", gaps, 0);
      if (v.exp_writes > 0) begin
         checkOutput("first_addr", first, v.exp_first);
         checkOutput("last_addr", last_a, v.exp_last);
         checkOutput("write_data", bad_data, 0);
         prev_addr = v.exp_last;
      end else begin
         checkOutput("addr_hold", done_addr, prev_addr);
      end
      @(negedge clk);
      checkOutput("ready_after_done", int'(cmd_ready), 1);
      checkOutput("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int bad_vis;
      int bad_invis;
      int fill_writes;
      int fill_bad;
      int extra;
      int dones;
      int writes;
      checks = 0; errors = 0; prev_addr = 0; bad_addr = 0;
      for (int a = 0; a < 2048; a++) ram[a] = 3'd7;

      vectors[0] = '{2'd0, 6'd5,  5'd3,  6'd0,  3'd6, 1,    'h0C5, 'h0C5};
      vectors[1] = '{2'd1, 6'd36, 5'd0,  6'd10, 3'd2, 4,    'h024, 'h027};
      vectors[2] = '{2'd2, 6'd0,  5'd28, 6'd5,  3'd5, 2,    'h700, 'h740};
      vectors[3] = '{2'd0, 6'd40, 5'd0,  6'd0,  3'd3, 0,    0,     0};
      vectors[4] = '{2'd1, 6'd3,  5'd4,  6'd0,  3'd3, 0,    0,     0};
      vectors[5] = '{2'd2, 6'd10, 5'd2,  6'd3,  3'd3, 3,    'h08A, 'h10A};
      vectors[6] = '{2'd0, 6'd0,  5'd30, 6'd0,  3'd2, 0,    0,     0};
      vectors[7] = '{2'd1, 6'd63, 5'd0,  6'd5,  3'd2, 0,    0,     0};
      vectors[8] = '{2'd1, 6'd0,  5'd29, 6'd63, 3'd4, 40,   'h740, 'h767};
      vectors[9] = '{2'd3, 6'd17, 5'd9,  6'd2,  3'd1, 1200, 'h000, 'h767};

      rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_x = '0; cmd_y = '0;
      cmd_len = '0; cmd_color = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready", int'(cmd_ready), 1);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_wea", int'(wea), 0);
      checkOutput("reset_addra", int'(addra), 0);
      checkOutput("reset_dina", int'(dina), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++)
         applyStimulus(vectors[i]);

      bad_vis = 0; bad_invis = 0;
      for (int a = 0; a < 2048; a++) begin
         if ((a % 64) < 40 && (a / 64) < 30) begin
            if (ram[a] != 3'd1) bad_vis++;
         end else begin
            if (ram[a] != 3'd7) bad_invis++;
         end
      end
      checkOutput("fill_visible_cells", bad_vis, 0);
      checkOutput("fill_offscreen_cells", bad_invis, 0);

      // FILL with a PLOT held on the bus: the PLOT waits, then runs once.
      waitReady();
      cmd_op = 2'd3; cmd_x = 6'd0; cmd_y = 5'd0; cmd_len = 6'd0; cmd_color = 3'd2;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_op = 2'd0; cmd_x = 6'd7; cmd_y = 5'd1; cmd_color = 3'd5;
      fill_writes = 0; fill_bad = 0; dones = 0;
      for (int c = 0; c < 1300 && dones == 0; c++) begin
         if (wea) begin
            fill_writes++;
            if (dina != 3'd2) fill_bad++;
         end
         if (done) dones = 1;
         else @(negedge clk);
      end
      checkOutput("hold_fill_writes", fill_writes, 1200);
      checkOutput("hold_fill_data", fill_bad, 0);
      @(negedge clk);
      checkOutput("hold_ready_returns", int'(cmd_ready), 1);
      checkOutput("hold_idle_wea", int'(wea), 0);
      @(negedge clk);
      checkOutput("hold_plot_wea", int'(wea), 1);
      checkOutput("hold_plot_addr", int'(addra), 'h047);
      checkOutput("hold_plot_data", int'(dina), 5);
      cmd_valid = 1'b0;
      extra = 0; dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (wea) extra++;
         if (done) dones++;
      end
      checkOutput("hold_plot_once", extra, 0);
      checkOutput("hold_plot_done", dones, 1);
      prev_addr = 'h047;

      // Reset in the middle of a FILL.
      waitReady();
      cmd_op = 2'd3; cmd_color = 3'd3; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      writes = 0;
      for (int c = 0; c < 1300 && writes < 600; c++) begin
         if (wea) writes++;
         if (writes < 600) @(negedge clk);
      end
      checkOutput("midreset_reached", writes, 600);
      rst = 1'b1;
      #1;
      checkOutput("midreset_wea", int'(wea), 0);
      checkOutput("midreset_ready", int'(cmd_ready), 1);
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_addra", int'(addra), 0);
      checkOutput("midreset_dina", int'(dina), 0);
      @(negedge clk);
      rst = 1'b0;
      prev_addr = 0;
      @(negedge clk);
      applyStimulus('{2'd0, 6'd10, 5'd10, 6'd0, 3'd6, 1, 'h28A, 'h28A});

      checkOutput("offscreen_writes", bad_addr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Write-side engine for the 40x30-cell, 3-bit-colour character frame buffer that the VGA scan-out reads on its port B. It accepts drawing commands (plot, horizontal line, vertical line, full fill) over a valid/ready handshake from the CPU peripheral decoder. It emits one port-A RAM write per clock, so firmware never has to compute cell addresses or loop over cells.

## Interface
- COLS, 40, visible columns (x range 0..COLS-1)
- ROWS, 30, visible rows (y range 0..ROWS-1)
- XW, 6, column index width; low field of the address
- YW, 5, row index width; high field of the address
- CW, 3, colour width

- clk  in  1  system clock; the same clock drives RAM port A
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle and able to accept a command
- cmd_op  in  2  opcode: 0 PLOT, 1 HLINE, 2 VLINE, 3 FILL
- cmd_x  in  XW  start column
- cmd_y  in  YW  start row
- cmd_len  in  6  cell count for HLINE/VLINE; ignored by PLOT/FILL
- cmd_color  in  CW  colour to write
- busy  out  1  high while a command is in progress (RUN or DONE)
- done  out  1  one-cycle pulse when a command completes
- addra  out  YW+XW  RAM port-A address, {y, x}
- dina  out  CW  RAM port-A write data
- wea  out  1  RAM port-A write enable

## Operation
- FSM states: IDLE, RUN, DONE. cmd_ready = (state==IDLE). busy = !cmd_ready.
- Accept: cmd_valid && cmd_ready at a rising edge. On that edge the engine latches op, colour, start cursor (cx,cy) and remaining count.
- Write count per opcode:
  - PLOT: 1.
  - HLINE: min(len, COLS-x). Cursor cx increments each write.
  - VLINE: min(len, ROWS-y). Cursor cy increments each write.
  - FILL: COLS*ROWS = 1200. Row-major order: cx runs 0..39, then wraps to 0 and cy increments; starts at (0,0). cmd_x/cmd_y are ignored.
- Clipping:
  - A start with x>=COLS or y>=ROWS (PLOT/HLINE/VLINE) produces zero writes.
  - A line with len=0 produces zero writes.
  - In both cases the FSM goes IDLE->DONE directly.
  - Cells with x in 40..63 are never written.
- In RUN: wea=1, addra={cy,cx}, dina=latched colour, every cycle with no gaps. The cursor advances on each edge. The final write's edge moves the FSM to DONE.
- DONE: lasts exactly one cycle; done=1, wea=0. Next state is IDLE.
- Outside RUN: wea=0, and addra/dina hold their last value.
- cmd_valid while busy is ignored. No queueing; the command is simply not accepted.
- Reset, including mid-command: state=IDLE and the in-flight command is abandoned. Reset values: cmd_ready=1, busy=0, done=0, wea=0, addra=0, dina=0.

## Timing
- Accept at edge k: first write occupies cycle k..k+1 (sampled by the RAM at edge k+1).
- An N-write command:
  - wea is high for N consecutive cycles.
  - done is high in cycle k+N..k+N+1.
  - cmd_ready returns high after edge k+N+1.
- Zero-write command: done is high in cycle k..k+1, and ready returns after edge k+1.
- Back-to-back PLOTs: one accepted every 3 cycles.
- FILL: 1200 write cycles + 1 DONE cycle, i.e. 24 µs at 50 MHz, well below one frame.
- Port-A writes are not synchronised to scan-out. The dual-port RAM resolves A/B collisions, and the display may show one transitional frame.

## Structure
- Shared package: COLS, ROWS, XW, YW, CW constants; opcode enum (OP_PLOT, OP_HLINE, OP_VLINE, OP_FILL); FSM state enum.
- One sub-module: fb_cursor. It holds the cx/cy registers and the remaining-count register.
  - Inputs: load, step, mode (H, V, raster).
  - Output: last, asserted when remaining==1.
  - The top-level keeps the FSM, the handshake and the output drive.

## Test plan
- Reset, then PLOT x=5 y=3 colour=6 -> one wea cycle with addra=0x0C5, dina=6; done one cycle later; cmd_ready high 3 cycles after accept.
- HLINE x=36 y=0 len=10 colour=2 -> exactly 4 writes at addra 0x024..0x027 (clipped at column 39), then done.
- VLINE x=0 y=28 len=5, then PLOT x=40 y=0, then HLINE len=0 -> VLINE does 2 writes (0x700, 0x740); PLOT and HLINE do zero writes but each pulses done.
- FILL colour=1 into a RAM model -> 1200 contiguous wea cycles; all (x<40, y<30) cells =1; cells with x>=40 untouched; last addra=0x767.
- Hold cmd_valid high during a FILL with a different PLOT on the bus -> PLOT is not accepted until cmd_ready returns, then executes once.
- Assert rst at write 600 of a FILL -> wea drops immediately; all outputs at reset values; next command executes normally.
